// File: rtl/alu_pkg.sv
// Shared constants for the ALU operand stage and its register file.
package alu_pkg;
   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int RW   = $clog2(NREG);
   localparam int OPW  = 7;

   localparam logic [OPW-1:0] OP_ADD = 7'd0;
   localparam logic [OPW-1:0] OP_SUB = 7'd1;
endpackage

// File: rtl/regfile_2r1w.sv
// NREG x XLEN register file: two async read ports, one sync write port, x0 hardwired to zero.
module regfile_2r1w #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int RW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we_i,
   input  logic [RW-1:0]   waddr_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [RW-1:0]   raddr1_i,
   output logic [XLEN-1:0] rdata1_o,
   input  logic [RW-1:0]   raddr2_i,
   output logic [XLEN-1:0] rdata2_o
);
   logic [XLEN-1:0] mem_q [NREG];

   // Storage: async clear, writes to x0 dropped so it never holds a value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      end else if (we_i && (waddr_i != '0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read ports: x0 forced to zero regardless of array content.
   always_comb begin
      rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
      rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];
   end
endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the ALU: register file, RAW/WAW scoreboard, writeback
// bypass and a one-entry registered output toward the ALU.
module alu_operand_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int OPW  = 7,
   parameter int RW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  in_op,
   input  logic [RW-1:0]   in_rs1,
   input  logic [RW-1:0]   in_rs2,
   input  logic [RW-1:0]   in_rd,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_use_imm,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [OPW-1:0]  alu_op,
   output logic [RW-1:0]   out_rd,
   input  logic            wb_en,
   input  logic [RW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data
);
   import alu_pkg::*;

   logic [XLEN-1:0] rf_rd1, rf_rd2;
   logic [XLEN-1:0] opa, opb;
   logic [NREG-1:0] pend_q, pend_d;
   logic            hz, accept;
   logic            vld_q, vld_d;
   logic [XLEN-1:0] a_q, b_q;
   logic [OPW-1:0]  op_q;
   logic [RW-1:0]   rd_q;

   regfile_2r1w #(.XLEN(XLEN), .NREG(NREG), .RW(RW)) u_rf (
      .clk      (clk),
      .rst      (rst),
      .we_i     (wb_en),
      .waddr_i  (wb_rd),
      .wdata_i  (wb_data),
      .raddr1_i (in_rs1),
      .rdata1_o (rf_rd1),
      .raddr2_i (in_rs2),
      .rdata2_o (rf_rd2)
   );

   // Hazard: a source (or the destination, for WAW) is pending and not being
   // written back this same cycle. pend_q[0] is never set, so x0 never stalls.
   always_comb begin
      hz = (pend_q[in_rs1] && !(wb_en && wb_rd == in_rs1))
         || (!in_use_imm && pend_q[in_rs2] && !(wb_en && wb_rd == in_rs2))
         || (pend_q[in_rd] && !(wb_en && wb_rd == in_rd));
      in_ready = !hz && (!vld_q || out_ready);
      accept   = in_valid && in_ready;
   end

   // Bypass: a same-cycle writeback to a nonzero source wins over the array.
   always_comb begin
      opa = (wb_en && wb_rd == in_rs1 && in_rs1 != '0) ? wb_data : rf_rd1;
      opb = in_use_imm ? in_imm
          : ((wb_en && wb_rd == in_rs2 && in_rs2 != '0) ? wb_data : rf_rd2);
   end

   // Scoreboard next state: clear on writeback first, so a same-edge set wins.
   always_comb begin
      pend_d = pend_q;
      if (wb_en && wb_rd != '0) pend_d[wb_rd] = 1'b0;
      if (accept && in_rd != '0) pend_d[in_rd] = 1'b1;
      vld_d = accept ? 1'b1 : (out_ready ? 1'b0 : vld_q);
   end

   // Scoreboard and output register; fields load only on accept and hold otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
         vld_q  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_ADD;
         rd_q   <= '0;
      end else begin
         pend_q <= pend_d;
         vld_q  <= vld_d;
         if (accept) begin
            a_q  <= opa;
            b_q  <= opb;
            op_q <= in_op;
            rd_q <= in_rd;
         end
      end
   end

   assign out_valid = vld_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign out_rd    = rd_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed table, reset corner, random vs model.
module tb_alu_operand_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_use_imm, out_valid, out_ready, wb_en;
   logic [6:0]  in_op, alu_op;
   logic [4:0]  in_rs1, in_rs2, in_rd, out_rd, wb_rd;
   logic [31:0] in_imm, alu_a, alu_b, wb_data;

   int tests = 0;
   int errs  = 0;

   always #5 clk = ~clk;

   alu_operand_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_imm(in_imm), .in_use_imm(in_use_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .out_rd(out_rd),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   typedef struct {
      logic        v;  logic [6:0] op; logic [4:0] rs1, rs2, rd;
      logic [31:0] imm; logic ui, ordy, we; logic [4:0] wrd; logic [31:0] wd;
      logic        e_rdy, e_v; logic [31:0] e_a, e_b; logic [6:0] e_op; logic [4:0] e_rd;
   } vec_t;

   vec_t tbl[14];

   // reference model state
   logic [31:0] m_reg [32];
   bit          m_pend[32];
   logic        m_v;
   logic [31:0] m_a, m_b;
   logic [6:0]  m_op;
   logic [4:0]  m_rd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(
      input logic v, input logic [6:0] op, input logic [4:0] rs1, rs2, rd,
      input logic [31:0] imm, input logic ui, ordy, we, input logic [4:0] wrd,
      input logic [31:0] wd, input logic e_rdy, e_v, input logic [31:0] e_a, e_b,
      input logic [6:0] e_op, input logic [4:0] e_rd);
      vec_t r;
      r.v = v; r.op = op; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.imm = imm;
      r.ui = ui; r.ordy = ordy; r.we = we; r.wrd = wrd; r.wd = wd;
      r.e_rdy = e_rdy; r.e_v = e_v; r.e_a = e_a; r.e_b = e_b; r.e_op = e_op; r.e_rd = e_rd;
      return r;
   endfunction

   task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rs1, rs2, rd,
                        input logic [31:0] imm, input logic ui, ordy, we,
                        input logic [4:0] wrd, input logic [31:0] wd);
      in_valid = v; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_imm = imm;
      in_use_imm = ui; out_ready = ordy; wb_en = we; wb_rd = wrd; wb_data = wd;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] a, b,
                          input logic [6:0] op, input logic [4:0] rd);
      chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
      chk({tag, ".alu_a"}, alu_a, a);
      chk({tag, ".alu_b"}, alu_b, b);
      chk({tag, ".alu_op"}, {25'd0, alu_op}, {25'd0, op});
      chk({tag, ".out_rd"}, {27'd0, out_rd}, {27'd0, rd});
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] r);
      if (r == 0) return 32'd0;
      if (wb_en && wb_rd == r) return wb_data;
      return m_reg[r];
   endfunction

   initial begin
      vec_t t;
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      #12;
      chk_out("reset", 0, 0, 0, 0, 0);
      chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      //           v op rs1 rs2 rd imm ui ordy we wrd wd           rdy v  a      b   op rd
      tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'd1,        1, 0, 0,     0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 32'd2,        1, 0, 0,     0, 0, 0);
      tbl[2]  = mk(1, 0, 1, 2, 3, 0, 0, 1, 0, 0, 0,            1, 1, 1,     2, 0, 3);
      tbl[3]  = mk(1, 1, 3, 0, 4, 0, 0, 1, 0, 0, 0,            0, 0, 1,     2, 0, 3);
      tbl[4]  = mk(1, 1, 3, 0, 4, 0, 0, 1, 0, 0, 0,            0, 0, 1,     2, 0, 3);
      tbl[5]  = mk(1, 1, 3, 0, 4, 0, 0, 1, 1, 3, 32'd7,        1, 1, 7,     0, 1, 4);
      tbl[6]  = mk(1, 1, 5, 4, 6, 2, 1, 1, 1, 5, 32'd7,        1, 1, 7,     2, 1, 6);
      tbl[7]  = mk(1, 0, 1, 2, 8, 0, 0, 0, 0, 0, 0,            0, 1, 7,     2, 1, 6);
      tbl[8]  = mk(1, 0, 1, 2, 8, 0, 0, 0, 0, 0, 0,            0, 1, 7,     2, 1, 6);
      tbl[9]  = mk(1, 0, 1, 2, 8, 0, 0, 0, 1, 5, 32'd100,      0, 1, 7,     2, 1, 6);
      tbl[10] = mk(1, 2, 5, 2, 8, 0, 0, 1, 0, 0, 0,            1, 1, 100,   2, 2, 8);
      tbl[11] = mk(1, 3, 0, 0, 0, 0, 0, 1, 1, 0, 32'hFFFFFFFF, 1, 1, 0,     0, 3, 0);
      tbl[12] = mk(1, 4, 0, 0, 0, 0, 0, 1, 0, 0, 0,            1, 1, 0,     0, 4, 0);
      tbl[13] = mk(1, 5, 0, 0, 4, 0, 0, 1, 0, 0, 0,            0, 0, 0,     0, 4, 0);

      for (int i = 0; i < 14; i++) begin
         string tag;
         t = tbl[i];
         tag = $sformatf("vec%0d", i);
         @(negedge clk);
         drive(t.v, t.op, t.rs1, t.rs2, t.rd, t.imm, t.ui, t.ordy, t.we, t.wrd, t.wd);
         #1 chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, t.e_rdy});
         @(posedge clk);
         #1 chk_out(tag, t.e_v, t.e_a, t.e_b, t.e_op, t.e_rd);
      end

      // Async reset while holding an entry and stalled on a pending source.
      @(negedge clk);
      drive(1, 5, 0, 0, 9, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1 chk_out("rs.load", 1, 0, 0, 5, 9);
      @(negedge clk);
      drive(1, 6, 9, 0, 10, 0, 0, 0, 0, 0, 0);
      #1 chk("rs.stall", {31'd0, in_ready}, 32'd0);
      #1 rst = 1'b1;
      #1 chk_out("rs.async", 0, 0, 0, 0, 0);
      chk("rs.ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 6, 9, 4, 9, 0, 0, 1, 0, 0, 0);
      #1 chk("rs.post_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1 chk_out("rs.post", 1, 0, 0, 6, 9);

      // Randomized run against the model.
      do_reset();
      for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_pend[i] = 0; end
      m_v = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0;
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] wr, cand;
         logic exp_rdy, acc;
         @(negedge clk);
         wr = 5'($urandom_range(0, 7));
         if ($urandom_range(0, 9) < 7) begin
            for (int k = 0; k < 8; k++) begin
               cand = 5'($urandom_range(1, 7));
               if (m_pend[cand]) begin wr = cand; break; end
            end
         end
         drive(1'($urandom), 7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), wr, $urandom);
         exp_rdy = 1'b1;
         if (m_pend[in_rs1] && !(wb_en && wb_rd == in_rs1)) exp_rdy = 1'b0;
         if (!in_use_imm && m_pend[in_rs2] && !(wb_en && wb_rd == in_rs2)) exp_rdy = 1'b0;
         if (m_pend[in_rd] && !(wb_en && wb_rd == in_rd)) exp_rdy = 1'b0;
         if (m_v && !out_ready) exp_rdy = 1'b0;
         acc = in_valid && exp_rdy;
         #1 chk("rnd.in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         if (acc) begin
            m_a = m_read(in_rs1);
            m_b = in_use_imm ? in_imm : m_read(in_rs2);
            m_op = in_op; m_rd = in_rd; m_v = 1'b1;
         end else if (out_ready) begin
            m_v = 1'b0;
         end
         if (wb_en && wb_rd != 0) begin m_reg[wb_rd] = wb_data; m_pend[wb_rd] = 0; end
         if (acc && in_rd != 0) m_pend[in_rd] = 1;
         @(posedge clk);
         #1 chk_out("rnd", m_v, m_a, m_b, m_op, m_rd);
      end

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the ALU. Holds the 32-entry register file and a RAW scoreboard.
- Accepts decoded instructions over a valid/ready handshake and reads or bypasses their operands.
- Presents registered a/b/operation/rd to the ALU and consumes ALU writebacks.
- Stalls issue while a source register awaits a pending writeback.

Parameters:
- XLEN, 32, operand/result width (matches ALU a/b/result)
- NREG, 32, number of architectural registers; index width RW = log2(NREG)
- OPW, 7, ALU operation code width (matches ALU operation port)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept this cycle
- in_op  input  OPW  ALU operation code (0 = add, 1 = sub, others passed through unchanged)
- in_rs1  input  RW  source register for a
- in_rs2  input  RW  source register for b
- in_rd  input  RW  destination register
- in_imm  input  XLEN  immediate
- in_use_imm  input  1  1: b = in_imm, rs2 ignored for read and hazard
- out_valid  output  1  ALU operands valid
- out_ready  input  1  downstream consumed operands
- alu_a  output  XLEN  to ALU a
- alu_b  output  XLEN  to ALU b
- alu_op  output  OPW  to ALU operation
- out_rd  output  RW  destination tag travelling with the result
- wb_en  input  1  writeback strobe
- wb_rd  input  RW  writeback register
- wb_data  input  XLEN  writeback value (ALU result)

Behaviour:
- Reset (async, any cycle, including mid-handshake):
  - out_valid=0; alu_a=0, alu_b=0, alu_op=0, out_rd=0.
  - All registers 0; scoreboard cleared; a held entry is discarded.
- Register 0 reads as 0 always. Writes to it are ignored, and it is never marked pending.
- Writeback: on wb_en with wb_rd!=0, reg[wb_rd] <= wb_data and pending[wb_rd] <= 0.
- Hazard: hz = (pending[rs1] && !(wb_en && wb_rd==rs1)) || (!in_use_imm && pending[rs2] && !(wb_en && wb_rd==rs2)).
- in_ready = !hz && (!out_valid || out_ready), combinational. A hazard stalls even when the output register is empty.
- Accept = in_valid && in_ready. On accept, at the next edge:
  - out_valid=1.
  - alu_a = bypassed rs1 value.
  - alu_b = in_use_imm ? in_imm : bypassed rs2 value.
  - alu_op=in_op, out_rd=in_rd.
  - If in_rd!=0, pending[in_rd]=1.
- Bypass: if wb_en && wb_rd==rsN && rsN!=0, use wb_data, else reg[rsN]. This gives zero-cycle forwarding.
- Same-edge set and clear of the same pending bit (accept with in_rd==wb_rd): set wins.
- Same-edge writeback and accept with a different rd: both take effect.
- out_valid && out_ready && !accept -> out_valid=0. Output fields hold their last value.
- While out_valid && !out_ready, all outputs are stable. Operands are captured at accept; later writebacks do not alter them.
- Latency: 1 cycle from accept to out_valid. Throughput 1/cycle with no hazard and out_ready high.
- Scoreboard has no counter: one in-flight write per register is assumed, enforced by the stall on rd==pending (WAW). A pending in_rd also raises hz.

Decomposition:
- Shared package alu_pkg: XLEN, OPW, NREG/RW constants, ALU op codes (OP_ADD=7'd0, OP_SUB=7'd1).
- Sub-module regfile_2r1w: NREG x XLEN array, two async read ports, one sync write port, x0 hardwired to zero, async reset clear.
- Scoreboard, bypass muxes and handshake register live in alu_operand_stage.

Test Plan:
- Reset release, wb x1=1, wb x2=2, issue op=0 rs1=1 rs2=2 rd=3 -> next cycle out_valid=1, alu_a=1, alu_b=2, alu_op=0, out_rd=3, pending[3]=1.
- Issue op=1 rs1=3 while x3 pending -> in_ready=0 for all cycles until wb_en rd=3 data=7. Bypass cycle: accept, alu_a=7.
- in_use_imm=1, imm=32'h00000002, rs1=5 (x5=7), op=1 -> alu_a=7, alu_b=2, no stall even if x(rs2) pending.
- out_ready=0 for 3 cycles with a held entry, then wb to its source -> outputs unchanged, in_ready=0 until out_ready=1, then back-to-back accept.
- rs1=0 with wb_en rd=0 data=32'hFFFFFFFF -> alu_a=0, pending[0] stays 0; rd=0 issue never stalls successors.
- Assert rst mid-stall with out_valid=1 -> out_valid=0 asynchronously, scoreboard clear, regs zero; first post-reset issue accepted immediately.
